// File: rtl/counter_control.sv
// Control FSM for the 16-bit counter datapath: sequences clear, paced +/-1 loads
// and completion from host commands and the datapath z/m flags.
module counter_control #(
   parameter int TICK_DIV = 4,
   parameter int TICK_W   = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic dir,
   input  logic stop,
   input  logic clr_req,
   input  logic z,
   input  logic m,
   output logic op,
   output logic c_ld,
   output logic c_clr,
   output logic busy,
   output logic done
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   state_t              state, state_nxt;
   logic                dir_r;
   logic [TICK_W-1:0]   tick_cnt;
   logic                tick_hit;
   logic                term;

   assign tick_hit = (tick_cnt == TICK_LAST);
   // z/m describe the current C, so checking them before each load prevents wrap
   assign term     = dir_r ? z : m;
   assign op       = dir_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         dir_r    <= 1'b0;
         tick_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && !clr_req && start)
            dir_r <= dir;
         // held at zero outside RUN, so every run starts its first tick period fresh
         if (state == RUN && !tick_hit)
            tick_cnt <= tick_cnt + 1'b1;
         else
            tick_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (clr_req)    state_nxt = CLEAR;
            else if (start) state_nxt = RUN;
         end
         CLEAR: state_nxt = IDLE;
         RUN: begin
            if (stop)                  state_nxt = IDLE;
            else if (tick_hit && term) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // stop must veto a load in the very cycle it is raised, hence its only output path
   always_comb begin
      c_ld  = 1'b0;
      c_clr = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state)
         CLEAR: begin
            c_clr = 1'b1;
            busy  = 1'b1;
         end
         RUN: begin
            busy = 1'b1;
            c_ld = tick_hit && !term && !stop;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule
